// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle. A shift-add multiplier and a restoring divider share
// a single 2*WIDTH accumulator. Divide-by-zero and signed overflow take a one-cycle
// fast path. The front of the pipeline is stalled until the result is ready.
//
// Handshake: an M op is presented by StartE. The unit holds the pipeline with
// StallMD until the op has completed. The instruction advances on the edge that
// ends the DONE cycle. In that cycle DoneE is high and ResultE is valid. Clear
// aborts any op and suppresses StallMD in the same cycle.
module execute_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             Clear,
   input  logic             StartE,
   input  logic [2:0]       Funct3E,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic             StallMD,
   output logic             BusyE,
   output logic             DoneE,
   output logic [WIDTH-1:0] ResultE,
   output logic [1:0]       StateE
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        cnt_q;
   logic [2:0]           funct3_q;
   logic                 neg_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   acc_q;

   // Operand decode at issue: signedness, magnitudes, result sign, fast-path result
   logic             a_signed, b_signed, a_neg, b_neg, neg_d;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             b_zero, ovf, fast;
   logic [WIDTH-1:0] fast_res;

   always_comb begin
      a_signed = Funct3E[2] ? ~Funct3E[0] : (Funct3E != 3'b011);
      b_signed = Funct3E[2] ? ~Funct3E[0] : ~Funct3E[1];
      a_neg    = a_signed & SrcAE[WIDTH-1];
      b_neg    = b_signed & SrcBE[WIDTH-1];
      a_mag    = a_neg ? -SrcAE : SrcAE;
      b_mag    = b_neg ? -SrcBE : SrcBE;
      // The remainder follows the dividend sign; everything else uses the sign product.
      neg_d    = (Funct3E[2] & Funct3E[1]) ? a_neg : (a_neg ^ b_neg);
      b_zero   = (SrcBE == '0);
      ovf      = Funct3E[2] & ~Funct3E[0] & (SrcAE == MIN_VAL) & (SrcBE == '1);
      fast     = Funct3E[2] & (b_zero | ovf);
      if (b_zero) fast_res = Funct3E[1] ? SrcAE : '1;
      else        fast_res = Funct3E[1] ? '0 : MIN_VAL;
   end

   // One iteration step and the sign-corrected final result taken from it
   logic [WIDTH:0]       mul_sum, div_tmp, div_diff;
   logic [2*WIDTH-1:0]   step_acc, prod_s;
   logic [WIDTH-1:0]     quot_s, rem_s, final_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_tmp  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_tmp - {1'b0, b_q};
      if (funct3_q[2]) begin
         // Restoring divide: keep the shifted remainder when the trial subtraction goes negative.
         if (div_diff[WIDTH]) step_acc = {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else                 step_acc = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         step_acc = {mul_sum, acc_q[WIDTH-1:1]};
      end
      prod_s = neg_q ? -step_acc : step_acc;
      quot_s = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
      rem_s  = neg_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
      case (funct3_q)
         3'b000:                 final_res = prod_s[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         final_res = quot_s;
         default:                final_res = rem_s;
      endcase
   end

   // Control FSM and datapath registers; reset beats Clear, and Clear beats everything else
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         funct3_q <= '0;
         neg_q    <= 1'b0;
         b_q      <= '0;
         acc_q    <= '0;
         ResultE  <= '0;
      end else if (Clear) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (StartE) begin
                  funct3_q <= Funct3E;
                  neg_q    <= neg_d;
                  b_q      <= b_mag;
                  acc_q    <= {{WIDTH{1'b0}}, a_mag};
                  cnt_q    <= '0;
                  if (fast) begin
                     ResultE <= fast_res;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               acc_q <= step_acc;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) begin
                  ResultE <= final_res;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Status decode and the combinational pipeline stall
   always_comb begin
      BusyE   = (state_q == S_BUSY);
      DoneE   = (state_q == S_DONE);
      StateE  = state_q;
      StallMD = ~Clear & (((state_q == S_IDLE) & StartE) | (state_q == S_BUSY));
   end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Testbench for execute_muldiv_unit: directed and randomized RV32M ops checked
// against a 64-bit arithmetic reference model, plus Clear, reset and back-to-back cases.
module tb_execute_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        Clear;
   logic        StartE;
   logic [2:0]  Funct3E;
   logic [31:0] SrcAE, SrcBE;
   logic        StallMD, BusyE, DoneE;
   logic [31:0] ResultE;
   logic [1:0]  StateE;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_result;

   execute_muldiv_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .Clear(Clear), .StartE(StartE),
      .Funct3E(Funct3E), .SrcAE(SrcAE), .SrcBE(SrcBE),
      .StallMD(StallMD), .BusyE(BusyE), .DoneE(DoneE),
      .ResultE(ResultE), .StateE(StateE)
   );

   // clock and reset block
   always #5 clock = ~clock;

   // Reference model in plain 64-bit arithmetic
   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      int ia, ib;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      ia = $signed(a);
      ib = $signed(b);
      r = '0;
      case (f3)
         3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
         3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
         3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
            else r = 32'(ia / ib);
         end
         3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
            else r = 32'(ia % ib);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
      return 33;
   endfunction

   // driver: issue one op at cycle 0, scramble operands afterwards, check stall, busy, latency and result
   task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      bit seen;
      logic [31:0] e;
      exp_q.push_back(exp);
      @(negedge clock);
      StartE = 1'b1; Funct3E = f3; SrcAE = a; SrcBE = b;
      #1;
      checks++;
      if (StallMD !== 1'b1) begin
         errors++;
         $display("FAIL %s stall_c0: got %b expected 1", name, StallMD);
      end
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(negedge clock);
         StartE = 1'b0; Funct3E = 3'($urandom); SrcAE = $urandom; SrcBE = $urandom;
         #1;
         checks++;
         if (StallMD !== 1'(c < lat)) begin
            errors++;
            $display("FAIL %s stall_c%0d: got %b expected %b", name, c, StallMD, c < lat);
         end
         checks++;
         if (BusyE !== 1'(c < lat)) begin
            errors++;
            $display("FAIL %s busy_c%0d: got %b expected %b", name, c, BusyE, c < lat);
         end
         if (DoneE === 1'b1) begin
            seen = 1'b1;
            e = exp_q.pop_front();
            checks++;
            if (c != lat) begin
               errors++;
               $display("FAIL %s latency: got %0d expected %0d", name, c, lat);
            end
            checks++;
            if (ResultE !== e) begin
               errors++;
               $display("FAIL %s result (f3=%0d a=%h b=%h): got %h expected %h", name, f3, a, b, ResultE, e);
            end
            last_result = e;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         e = exp_q.pop_front();
         $display("FAIL %s timeout: got no DoneE expected DoneE in cycle %0d", name, lat);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Clear = 1'b0; StartE = 1'b0; Funct3E = '0; SrcAE = '0; SrcBE = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({ResultE, DoneE, BusyE, StallMD, StateE} !== 37'h0) begin
         errors++;
         $display("FAIL reset_state: got res=%h done=%b busy=%b stall=%b state=%0d expected all 0",
                  ResultE, DoneE, BusyE, StallMD, StateE);
      end
      last_result = '0;
   endtask

   task automatic test_multiply();
      do_op("mul_7x-3",    3'd0, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      do_op("mulh_7x-3",   3'd1, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
      do_op("mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      do_op("mulhsu_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      do_op("mul_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
   endtask

   task automatic test_divide();
      do_op("div_-7/2",   3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
      do_op("rem_-7/2",   3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
      do_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
      do_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
   endtask

   task automatic test_fast_path();
      do_op("div_5/0",   3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      do_op("remu_5/0",  3'd7, 32'd5, 32'd0, 32'd5, 1);
      do_op("divu_5/0",  3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      do_op("rem_-9/0",  3'd6, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 1);
      do_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      do_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
   endtask

   task automatic test_clear();
      int dones;
      @(negedge clock);
      StartE = 1'b1; Funct3E = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clock);
         StartE = 1'b0;
         if (c == 10) Clear = 1'b1;
      end
      #1;
      checks++;
      if (StallMD !== 1'b0) begin
         errors++;
         $display("FAIL clear_stall: got %b expected 0", StallMD);
      end
      @(negedge clock);
      Clear = 1'b0;
      #1;
      checks++;
      if ({BusyE, DoneE, StateE} !== 4'b0) begin
         errors++;
         $display("FAIL clear_idle: got busy=%b done=%b state=%0d expected idle", BusyE, DoneE, StateE);
      end
      checks++;
      if (ResultE !== last_result) begin
         errors++;
         $display("FAIL clear_result_hold: got %h expected %h", ResultE, last_result);
      end
      dones = 0;
      repeat (30) begin
         @(negedge clock);
         #1;
         if (DoneE === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL clear_no_done: got %0d pulses expected 0", dones);
      end
      do_op("divu_9/3", 3'd5, 32'd9, 32'd3, 32'd3, 33);
   endtask

   task automatic test_reset_mid();
      int dones;
      @(negedge clock);
      StartE = 1'b1; Funct3E = 3'd0; SrcAE = 32'd12345; SrcBE = 32'd678;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         StartE = 1'b0;
         if (c == 20) reset = 1'b1;
      end
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if ({ResultE, DoneE, BusyE, StallMD, StateE} !== 37'h0) begin
         errors++;
         $display("FAIL reset_mid: got res=%h done=%b busy=%b stall=%b state=%0d expected all 0",
                  ResultE, DoneE, BusyE, StallMD, StateE);
      end
      last_result = '0;
      dones = 0;
      repeat (40) begin
         @(negedge clock);
         #1;
         if (DoneE === 1'b1) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      int pulses, first, second;
      logic [31:0] e;
      exp_q.push_back(32'd56088);   // MUL 123 * 456
      exp_q.push_back(32'hFFFFFF9C); // DIV -1000 / 10
      pulses = 0; first = -1; second = -1;
      @(negedge clock);
      StartE = 1'b1; Funct3E = 3'd0; SrcAE = 32'd123; SrcBE = 32'd456;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clock);
         if (pulses == 1 && c == first + 1) begin
            Funct3E = 3'd4; SrcAE = 32'hFFFFFC18; SrcBE = 32'd10;
         end
         if (pulses >= 2) StartE = 1'b0;
         #1;
         if (DoneE === 1'b1) begin
            pulses++;
            if (pulses == 1) first = c;
            if (pulses == 2) second = c;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               if (ResultE !== e) begin
                  errors++;
                  $display("FAIL b2b_result%0d: got %h expected %h", pulses, ResultE, e);
               end
            end
         end
      end
      StartE = 1'b0;
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL b2b_pulses: got %0d expected 2", pulses);
      end
      checks++;
      if (first != 33 || second - first != 34) begin
         errors++;
         $display("FAIL b2b_spacing: got first=%0d gap=%0d expected first=33 gap=34", first, second - first);
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] a, b;
      for (int i = 0; i < 48; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = -a;
            default: ;
         endcase
         do_op("random", f3, a, b, ref_result(f3, a, b), ref_latency(f3, a, b));
      end
   endtask

   initial begin
      test_reset();
      test_multiply();
      test_divide();
      test_fast_path();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
